// File: rtl/rm_violation_collector.sv
// ============================================================================
// Module      : rm_violation_collector
// Description : Turns rising runtime-monitor rule outputs into sticky pending
//               violations, reports them lowest-index first over valid/ready,
//               halts all lanes while any is unreported, and counts reports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rm_violation_collector #(
    parameter int NUM_LANES = 4,
    parameter int NUM_RULES = 16,
    parameter int CNT_W     = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_LANES*NUM_RULES-1:0] monitor_i,
    input  logic [NUM_LANES-1:0]           lane_active_i,
    input  logic [NUM_LANES-1:0]           lane_reset_i,
    input  logic                           clear_i,
    output logic                           hault_o,
    output logic                           viol_valid_o,
    output logic [$clog2(NUM_LANES)-1:0]   viol_lane_o,
    output logic [$clog2(NUM_RULES)-1:0]   viol_rule_o,
    input  logic                           viol_ready_i,
    output logic [CNT_W-1:0]               viol_count_o
);

    localparam int NUM_BITS = NUM_LANES * NUM_RULES;
    localparam int IDX_W    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int LANE_W   = $clog2(NUM_LANES);
    localparam int RULE_W   = $clog2(NUM_RULES);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REPORT = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_BITS-1:0]   prev_q, prev_d;
    logic [NUM_BITS-1:0]   pending_q, pending_d;
    logic [NUM_BITS-1:0]   lane_mask, rise, ack_clr;
    logic [IDX_W-1:0]      sel_q, sel_d, low_idx;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  handshake;

    // Per-lane gating: a lane in reset forgets its history so a level still
    // high when it leaves reset is seen as a fresh rise.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign lane_mask[l*NUM_RULES +: NUM_RULES] =
            {NUM_RULES{lane_active_i[l] & ~lane_reset_i[l]}};
        assign prev_d[l*NUM_RULES +: NUM_RULES] =
            lane_reset_i[l] ? '0 : monitor_i[l*NUM_RULES +: NUM_RULES];
    end

    assign rise      = monitor_i & ~prev_q & lane_mask;
    assign handshake = (state_q == ST_REPORT) && viol_ready_i;

    always_comb begin
        ack_clr = '0;
        if (handshake) begin
            ack_clr[sel_q] = 1'b1;
        end
    end

    always_comb begin
        low_idx = '0;
        for (int i = NUM_BITS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        pending_d = (pending_q & ~ack_clr) | rise;
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    sel_d   = low_idx;
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (handshake) begin
                    state_d = ST_IDLE;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Clear overrides rises and a same-cycle handshake; prev_q is untouched.
        if (clear_i) begin
            pending_d = '0;
            cnt_d     = '0;
            sel_d     = '0;
            state_d   = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            prev_q    <= '0;
            pending_q <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
        end
    end

    assign hault_o      = |pending_q;
    assign viol_valid_o = (state_q == ST_REPORT);
    assign viol_lane_o  = LANE_W'(int'(sel_q) / NUM_RULES);
    assign viol_rule_o  = RULE_W'(int'(sel_q) % NUM_RULES);
    assign viol_count_o = cnt_q;

endmodule

`default_nettype wire
